// File: rtl/sd_fifo_word_packer_if.sv
// Byte-FIFO read port and 32-bit word stream shared by the SD word packer and its neighbours.
// master = packer side, slave = FIFO / downstream side.
interface sd_fifo_word_packer_if;
   logic        fifo_rd_en;
   logic [7:0]  fifo_rd_data;
   logic        fifo_empty;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic        m_last;

   modport master (
      output fifo_rd_en,
      input  fifo_rd_data,
      input  fifo_empty,
      output m_valid,
      input  m_ready,
      output m_data,
      output m_last
   );

   modport slave (
      input  fifo_rd_en,
      output fifo_rd_data,
      output fifo_empty,
      input  m_valid,
      output m_ready,
      input  m_data,
      input  m_last
   );
endinterface

// File: rtl/sd_fifo_word_packer.sv
// Drains whole sectors from the SD byte FIFO and packs them little-endian into 32-bit stream words.
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing FIFO reads, packing lanes, presenting words
// FIN   | one-cycle done pulse
module sd_fifo_word_packer #(
   parameter int SECTOR_BYTES = 512,
   parameter int CNT_W        = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [CNT_W-1:0]      sector_cnt_i,
   input  logic                  abort_i,
   output logic                  busy_o,
   output logic                  done_o,
   sd_fifo_word_packer_if.master bus
);
   localparam int WPS   = SECTOR_BYTES / 4;
   localparam int WIS_W = (WPS > 1) ? $clog2(WPS) : 1;
   localparam int TW_W  = CNT_W + WIS_W;
   localparam logic [WIS_W-1:0] LAST_WIS = WIS_W'(WPS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] secs_left_q, secs_left_d;
   logic [TW_W-1:0]  total_words_q, total_words_d;
   logic [TW_W-1:0]  words_issued_q, words_issued_d;
   logic [2:0]       bytes_issued_q, bytes_issued_d;
   logic [1:0]       lane_idx_q, lane_idx_d;
   logic             inflight_q, inflight_d;
   logic [23:0]      pack_q, pack_d;
   logic [WIS_W-1:0] word_in_sec_q, word_in_sec_d;
   logic [31:0]      out_data_q, out_data_d;
   logic             out_last_q, out_last_d;
   logic             out_valid_q, out_valid_d;

   logic             rd_en;
   logic             hs;
   logic             cap3;
   logic [2:0]       bytes_eff;
   logic             lane3_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         secs_left_q    <= '0;
         total_words_q  <= '0;
         words_issued_q <= '0;
         bytes_issued_q <= '0;
         lane_idx_q     <= '0;
         inflight_q     <= 1'b0;
         pack_q         <= '0;
         word_in_sec_q  <= '0;
         out_data_q     <= '0;
         out_last_q     <= 1'b0;
         out_valid_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         secs_left_q    <= secs_left_d;
         total_words_q  <= total_words_d;
         words_issued_q <= words_issued_d;
         bytes_issued_q <= bytes_issued_d;
         lane_idx_q     <= lane_idx_d;
         inflight_q     <= inflight_d;
         pack_q         <= pack_d;
         word_in_sec_q  <= word_in_sec_d;
         out_data_q     <= out_data_d;
         out_last_q     <= out_last_d;
         out_valid_q    <= out_valid_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      secs_left_d    = secs_left_q;
      total_words_d  = total_words_q;
      words_issued_d = words_issued_q;
      bytes_issued_d = bytes_issued_q;
      lane_idx_d     = lane_idx_q;
      inflight_d     = 1'b0;
      pack_d         = pack_q;
      word_in_sec_d  = word_in_sec_q;
      out_data_d     = out_data_q;
      out_last_d     = out_last_q;
      out_valid_d    = out_valid_q;
      rd_en          = 1'b0;

      hs        = out_valid_q & bus.m_ready;
      cap3      = inflight_q & (lane_idx_q == 2'd3);
      // A lane-3 capture this cycle frees the word slot, so the next word may start issuing now.
      bytes_eff = cap3 ? 3'd0 : bytes_issued_q;
      // Lane 3 only goes out if the output register will be free when its byte lands.
      lane3_ok  = (bytes_eff != 3'd3) | ~out_valid_q | bus.m_ready;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (sector_cnt_i != '0) begin
                  state_d        = S_RUN;
                  secs_left_d    = sector_cnt_i;
                  total_words_d  = TW_W'(sector_cnt_i) * TW_W'(WPS);
                  words_issued_d = '0;
                  bytes_issued_d = '0;
                  lane_idx_d     = '0;
                  word_in_sec_d  = '0;
               end else begin
                  state_d = S_FIN;
               end
            end
         end

         S_RUN: begin
            rd_en = ~bus.fifo_empty & (bytes_eff < 3'd4) &
                    (words_issued_q < total_words_q) & lane3_ok;
            bytes_issued_d = bytes_eff + {2'b00, rd_en};
            if (rd_en && (bytes_eff == 3'd3)) begin
               words_issued_d = words_issued_q + TW_W'(1);
            end
            inflight_d = rd_en;

            if (hs) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               if (out_last_q) begin
                  secs_left_d = secs_left_q - CNT_W'(1);
                  if (secs_left_q == CNT_W'(1)) begin
                     state_d = S_FIN;
                  end
               end
            end

            if (inflight_q) begin
               case (lane_idx_q)
                  2'd0: pack_d[7:0]   = bus.fifo_rd_data;
                  2'd1: pack_d[15:8]  = bus.fifo_rd_data;
                  2'd2: pack_d[23:16] = bus.fifo_rd_data;
                  default: begin
                     out_data_d    = {bus.fifo_rd_data, pack_q};
                     out_valid_d   = 1'b1;
                     out_last_d    = (word_in_sec_q == LAST_WIS);
                     word_in_sec_d = (word_in_sec_q == LAST_WIS) ? '0 : word_in_sec_q + WIS_W'(1);
                  end
               endcase
               lane_idx_d = lane_idx_q + 2'd1;
            end
         end

         S_FIN: begin
            state_d        = S_IDLE;
            secs_left_d    = '0;
            total_words_d  = '0;
            words_issued_d = '0;
            bytes_issued_d = '0;
            lane_idx_d     = '0;
            word_in_sec_d  = '0;
         end

         default: state_d = S_IDLE;
      endcase

      if (abort_i) begin
         state_d        = S_IDLE;
         secs_left_d    = '0;
         total_words_d  = '0;
         words_issued_d = '0;
         bytes_issued_d = '0;
         lane_idx_d     = '0;
         inflight_d     = 1'b0;
         pack_d         = '0;
         word_in_sec_d  = '0;
         out_data_d     = '0;
         out_last_d     = 1'b0;
         out_valid_d    = 1'b0;
      end
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.m_valid    = out_valid_q;
   assign bus.m_data     = out_data_q;
   assign bus.m_last     = out_last_q;
   assign busy_o         = (state_q != S_IDLE);
   assign done_o         = (state_q == S_FIN);
endmodule

// File: tb/tb_sd_fifo_word_packer.sv
// Self-checking bench for sd_fifo_word_packer: behavioural byte FIFO, stream monitor and
// a word-level reference model built directly from the byte stream pushed into the FIFO.
module tb_sd_fifo_word_packer;
   localparam int SECTOR_BYTES = 512;
   localparam int CNT_W        = 16;
   localparam int WPS          = SECTOR_BYTES / 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [CNT_W-1:0] sector_cnt;
   logic             abort;
   logic             busy;
   logic             done;

   sd_fifo_word_packer_if bus();

   sd_fifo_word_packer #(.SECTOR_BYTES(SECTOR_BYTES), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start),
      .sector_cnt_i (sector_cnt),
      .abort_i      (abort),
      .busy_o       (busy),
      .done_o       (done),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // cycle index, stable at every negedge
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // behavioural FIFO: data appears the cycle after an accepted read
   logic [7:0] mem [0:16383];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   logic       rd_seen = 1'b0;
   logic       flush_req = 1'b0;
   assign bus.fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (flush_req) begin
         rd_ptr <= wr_ptr;
      end else if (rd_seen && (rd_ptr != wr_ptr)) begin
         bus.fifo_rd_data <= mem[rd_ptr];
         rd_ptr           <= rd_ptr + 1;
      end
   end

   // downstream ready: 0 = always, 1 = one cycle in three, 2 = random
   int ready_mode = 0;
   int ph = 0;
   always @(posedge clk) begin
      #1;
      ph = (ph + 1) % 3;
      case (ready_mode)
         1:       bus.m_ready = (ph == 0);
         2:       bus.m_ready = 1'($urandom_range(0, 1));
         default: bus.m_ready = 1'b1;
      endcase
   end

   // stream monitor
   logic [31:0] out_w[$];
   logic        out_l[$];
   int          hs_cyc[$];
   int          rd_total = 0;
   int          rd_empty_err = 0;
   int          done_total = 0;
   int          stab_err = 0;
   logic        stall_prev = 1'b0;
   logic [31:0] data_prev = '0;
   logic        last_prev = 1'b0;

   always @(negedge clk) begin
      rd_seen = bus.fifo_rd_en;
      if (bus.fifo_rd_en) rd_total++;
      if (bus.fifo_rd_en && bus.fifo_empty) rd_empty_err++;
      if (done) done_total++;
      if (stall_prev && rst_n &&
          (!bus.m_valid || bus.m_data !== data_prev || bus.m_last !== last_prev)) stab_err++;
      stall_prev = rst_n && bus.m_valid && !bus.m_ready;
      data_prev  = bus.m_data;
      last_prev  = bus.m_last;
      if (rst_n && bus.m_valid && bus.m_ready) begin
         out_w.push_back(bus.m_data);
         out_l.push_back(bus.m_last);
         hs_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr++;
   endtask

   task automatic flush_fifo();
      @(posedge clk); #1 flush_req = 1'b1;
      @(posedge clk); #1 flush_req = 1'b0;
   endtask

   task automatic pulse_start(input int cnt, output int start_cyc);
      @(posedge clk); #1;
      start      = 1'b1;
      sector_cnt = CNT_W'(cnt);
      @(negedge clk);
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // full transfer checked against the reference model
   task automatic run_xfer(input string nm, input int cnt, input int mode, input bit pattern,
                           input bit poke, input int exp_words, input int exp_reads);
      logic [7:0]  bq[$];
      logic [7:0]  b;
      logic [31:0] ew;
      logic        el;
      int bw, br, bd, bs, be, start_cyc, first_rd, done_cyc, nbad, budget;
      bit seen_done;
      flush_fifo();
      for (int i = 0; i < cnt * SECTOR_BYTES; i++) begin
         b = pattern ? 8'(i) : 8'($urandom);
         bq.push_back(b);
         push_byte(b);
      end
      ready_mode = mode;
      bw = out_w.size(); br = rd_total; bd = done_total; bs = stab_err; be = rd_empty_err;
      pulse_start(cnt, start_cyc);
      first_rd  = -1;
      done_cyc  = -1;
      seen_done = 1'b0;
      budget    = cnt * SECTOR_BYTES * 8 + 100;
      for (int t = 0; t < budget && !seen_done; t++) begin
         @(negedge clk);
         if (poke && t == 100) begin start = 1'b1; sector_cnt = CNT_W'(5); end
         if (poke && t == 101) begin start = 1'b0; sector_cnt = CNT_W'(cnt); end
         if (first_rd < 0 && bus.fifo_rd_en) first_rd = cyc;
         if (done) begin seen_done = 1'b1; done_cyc = cyc; end
      end
      chk({nm, "_done_seen"}, 64'(seen_done), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      chk({nm, "_done_count"}, 64'(done_total - bd), 64'd1);
      chk({nm, "_words"}, 64'(out_w.size() - bw), 64'(exp_words));
      chk({nm, "_reads"}, 64'(rd_total - br), 64'(exp_reads));
      chk({nm, "_stable"}, 64'(stab_err - bs), 64'd0);
      chk({nm, "_rd_empty"}, 64'(rd_empty_err - be), 64'd0);
      nbad = 0;
      for (int k = 0; k < bq.size() / 4 && bw + k < out_w.size(); k++) begin
         ew = {bq[4*k+3], bq[4*k+2], bq[4*k+1], bq[4*k]};
         el = ((k % WPS) == WPS - 1);
         if (out_w[bw+k] !== ew || out_l[bw+k] !== el) begin
            if (nbad == 0)
               $display("  %s first bad word %0d: got 0x%08h/%0b want 0x%08h/%0b",
                        nm, k, out_w[bw+k], out_l[bw+k], ew, el);
            nbad++;
         end
      end
      chk({nm, "_model"}, 64'(nbad), 64'd0);
      if (cnt == 0) begin
         chk({nm, "_done_lat"}, 64'(done_cyc - start_cyc), 64'd1);
      end else begin
         chk({nm, "_first_rd_lat"}, 64'(first_rd - start_cyc), 64'd1);
         if (hs_cyc.size() > bw)
            chk({nm, "_done_after_last"}, 64'(done_cyc - hs_cyc[hs_cyc.size()-1]), 64'd1);
         if (mode == 0 && hs_cyc.size() > bw)
            chk({nm, "_throughput"}, 64'(hs_cyc[hs_cyc.size()-1] - hs_cyc[bw]),
                64'(4 * (exp_words - 1)));
      end
      if (pattern && cnt == 1 && out_w.size() >= bw + WPS) begin
         chk({nm, "_w0"}, 64'(out_w[bw]), 64'h0302_0100);
         chk({nm, "_w64"}, 64'(out_w[bw+64]), 64'h0302_0100);
         chk({nm, "_w127"}, 64'(out_w[bw+127]), 64'hFFFE_FDFC);
         chk({nm, "_last127"}, 64'(out_l[bw+127]), 64'd1);
         chk({nm, "_last126"}, 64'(out_l[bw+126]), 64'd0);
      end
   endtask

   typedef struct {
      int cnt;
      int mode;
      bit pattern;
      bit poke;
      int exp_words;
      int exp_reads;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int bw, br, bd, sc;
      bit reached;
      vecs[0] = '{1, 0, 1'b1, 1'b0, 128, 512};
      vecs[1] = '{1, 1, 1'b1, 1'b0, 128, 512};
      vecs[2] = '{3, 0, 1'b0, 1'b0, 384, 1536};
      vecs[3] = '{2, 2, 1'b0, 1'b1, 256, 1024};
      vecs[4] = '{0, 0, 1'b0, 1'b0, 0, 0};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; sector_cnt = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 64'({bus.m_valid, bus.m_last, bus.m_data, busy, done, bus.fifo_rd_en}), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_idle", 64'({bus.m_valid, busy, done, bus.fifo_rd_en}), 64'd0);

      for (int i = 0; i < 5; i++)
         run_xfer($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].mode, vecs[i].pattern,
                  vecs[i].poke, vecs[i].exp_words, vecs[i].exp_reads);

      // starvation: 6 bytes, gap, 2 more bytes
      flush_fifo();
      ready_mode = 0;
      for (int i = 0; i < 6; i++) push_byte(8'h11 + 8'(i));
      bw = out_w.size(); br = rd_total; bd = done_total;
      pulse_start(1, sc);
      repeat (20) @(negedge clk);
      chk("starve_words", 64'(out_w.size() - bw), 64'd1);
      if (out_w.size() > bw) chk("starve_w0", 64'(out_w[bw]), 64'h1413_1211);
      chk("starve_reads", 64'(rd_total - br), 64'd6);
      chk("starve_valid_low", 64'(bus.m_valid), 64'd0);
      chk("starve_busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
      push_byte(8'h17);
      push_byte(8'h18);
      repeat (8) @(negedge clk);
      chk("refill_words", 64'(out_w.size() - bw), 64'd2);
      if (out_w.size() > bw + 1) chk("refill_w1", 64'(out_w[bw+1]), 64'h1817_1615);
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      chk("starve_abort_busy", 64'(busy), 64'd0);

      // abort near word 40 of sector 0
      flush_fifo();
      for (int i = 0; i < SECTOR_BYTES; i++) push_byte(8'(i));
      bw = out_w.size(); bd = done_total;
      pulse_start(1, sc);
      reached = 1'b0;
      for (int t = 0; t < 1000 && !reached; t++) begin
         @(negedge clk);
         if (out_w.size() - bw >= 40) reached = 1'b1;
      end
      chk("abort_reached_w40", 64'(reached), 64'd1);
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      chk("abort_valid_low", 64'(bus.m_valid), 64'd0);
      chk("abort_busy_low", 64'(busy), 64'd0);
      repeat (10) @(negedge clk);
      chk("abort_no_done", 64'(done_total - bd), 64'd0);
      run_xfer("restart", 1, 0, 1'b0, 1'b0, 128, 512);

      // abort and start together: abort wins
      br = rd_total;
      @(posedge clk); #1 start = 1'b1; abort = 1'b1; sector_cnt = CNT_W'(1);
      @(posedge clk); #1 start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("abort_start_busy", 64'(busy), 64'd0);
      repeat (4) @(negedge clk);
      chk("abort_start_reads", 64'(rd_total - br), 64'd0);

      // async reset mid-word
      flush_fifo();
      for (int i = 0; i < SECTOR_BYTES; i++) push_byte(8'(i));
      pulse_start(1, sc);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async_rst_outputs",
          64'({bus.m_valid, bus.m_last, bus.m_data, busy, done, bus.fifo_rd_en}), 64'd0);
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
      run_xfer("post_rst", 1, 0, 1'b1, 1'b0, 128, 512);

      chk("rd_while_empty_total", 64'(rd_empty_err), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
